wb_io_ports: RTL and testbench

WB_IO_PORTS -- requirements
Module: wb_io_ports

---
 rtl/wb_io_ports_if.sv | 25 ++
 rtl/wb_io_ports.sv | 173 +++++++++++++++++
 tb/tb_wb_io_ports.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_io_ports_if.sv
// Wishbone pipelined slave bus bundle for wb_io_ports (cyc/stb/we/adr/dat/ack/stall).
// AW must equal CHW+2 of the attached wb_io_ports (channel bits plus two bank bits).
// master drives request fields and sees ack/stall/dat_o; slave is the mirror image.
interface wb_io_ports_if #(
    parameter int AW = 4
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [15:0]   dat_i;
    logic [15:0]   dat_o;
    logic          ack;
    logic          stall;

    modport master (
        output cyc, stb, we, adr, dat_i,
        input  dat_o, ack, stall
    );

    modport slave (
        input  cyc, stb, we, adr, dat_i,
        output dat_o, ack, stall
    );
endinterface

// File: rtl/wb_io_ports.sv
// Wishbone-mapped I/O port block: output registers, synchronised inputs, change flags, IRQ mask.
// Latency: ack WAIT+1 cycles after accept (1 cycle when WAIT=0); io_out updates the cycle after accept.
// Backpressure: stall held high while a wait-stated access is in flight; one request outstanding max.
// Ports: clk_i, rst_i (sync, active high); wb (slave modport, adr = {bank, channel});
//        io_in_i (async inputs, N_CH*DW), io_out_o (registered outputs), irq_o (level interrupt).
// Optional change-detect / interrupt logic (banks 10 and 11) is built only with WB_IO_PORTS_IRQ_EN.
module wb_io_ports #(
    parameter int N_CH = 4,
    parameter int DW   = 16,
    parameter int WAIT = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    wb_io_ports_if.slave         wb,
    input  logic [N_CH*DW-1:0]   io_in_i,
    output logic [N_CH*DW-1:0]   io_out_o,
    output logic                 irq_o
);
    localparam int             CHW   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CHW:0]   NCH_V = (CHW+1)'(N_CH);

    typedef enum logic {IDLE, WAIT_ST} state_t;

    state_t                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic                      ack_q, ack_d;
    logic [15:0]               dat_q, dat_d;
    logic [CHW+1:0]            adr_q;
    logic                      we_q;
    logic [N_CH-1:0][DW-1:0]   out_q, sync1_q, sync2_q;

    logic                      stall, accept, wr_en;
    logic [CHW-1:0]            req_ch, rd_ch;
    logic [1:0]                req_bank, rd_bank;
    logic                      req_ch_ok, rd_ch_ok;
    logic [CHW+1:0]            rd_adr;
    logic [15:0]               rd_data;

    assign stall     = (state_q == WAIT_ST);
    assign accept    = wb.cyc & wb.stb & ~stall;
    assign req_ch    = wb.adr[CHW-1:0];
    assign req_bank  = wb.adr[CHW+1:CHW];
    assign req_ch_ok = {1'b0, req_ch} < NCH_V;
    assign wr_en     = accept & wb.we & req_ch_ok;

    // Read data is taken at the ack edge: the live address for zero-wait accesses,
    // the captured address when the ack comes out of WAIT_ST.
    assign rd_adr   = stall ? adr_q : wb.adr;
    assign rd_ch    = rd_adr[CHW-1:0];
    assign rd_bank  = rd_adr[CHW+1:CHW];
    assign rd_ch_ok = {1'b0, rd_ch} < NCH_V;

`ifdef WB_IO_PORTS_IRQ_EN
    logic [N_CH-1:0][DW-1:0]   prev_q;
    logic [N_CH-1:0]           flag_q, mask_q, chg, clr;
    logic                      irq_q;

    always_comb begin
        chg = '0;
        for (int i = 0; i < N_CH; i++) begin
            chg[i] = |(sync2_q[i] ^ prev_q[i]);
        end
    end

    assign clr = (wr_en && req_bank == 2'b10) ? wb.dat_i[N_CH-1:0] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= '0;
            flag_q <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            prev_q <= sync2_q;
            // A fresh change outranks a clear landing on the same edge.
            flag_q <= (flag_q & ~clr) | chg;
            if (wr_en && req_bank == 2'b11) begin
                mask_q <= wb.dat_i[N_CH-1:0];
            end
            irq_q  <= |(flag_q & mask_q);
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    // Flag and mask banks return the whole per-channel bit vector; the channel
    // field only has to be in range for the access to take effect.
    always_comb begin
        rd_data = '0;
        if (rd_ch_ok) begin
            case (rd_bank)
                2'b00: rd_data[DW-1:0] = out_q[rd_ch];
                2'b01: rd_data[DW-1:0] = sync2_q[rd_ch];
`ifdef WB_IO_PORTS_IRQ_EN
                2'b10: rd_data[N_CH-1:0] = flag_q;
                2'b11: rd_data[N_CH-1:0] = mask_q;
`endif
                default: rd_data = '0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT == 0) begin
                        ack_d = 1'b1;
                        if (!wb.we) dat_d = rd_data;
                    end else begin
                        state_d = WAIT_ST;
                        cnt_d   = 4'(WAIT);
                    end
                end
            end
            WAIT_ST: begin
                if (!wb.cyc) begin
                    // Master gave up: drop the access silently; any write already landed.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                    if (!we_q) dat_d = rd_data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            out_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            if (accept) begin
                adr_q <= wb.adr;
                we_q  <= wb.we;
            end
            sync1_q <= io_in_i;
            sync2_q <= sync1_q;
            if (wr_en && req_bank == 2'b00) begin
                out_q[req_ch] <= wb.dat_i[DW-1:0];
            end
        end
    end

    assign wb.ack   = ack_q;
    assign wb.stall = stall;
    assign wb.dat_o = dat_q;
    assign io_out_o = out_q;
endmodule

// File: tb/tb_wb_io_ports.sv
module tb_wb_io_ports;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  adr;
    logic [15:0] dat;
    logic [1:0]  sel;

    wb_io_ports_if #(.AW(4)) wb0 ();
    wb_io_ports_if #(.AW(4)) wb1 ();
    wb_io_ports_if #(.AW(4)) wb2 ();

    assign wb0.cyc = cyc && (sel == 2'd0);
    assign wb0.stb = stb && (sel == 2'd0);
    assign wb0.we = we;
    assign wb0.adr = adr;
    assign wb0.dat_i = dat;
    assign wb1.cyc = cyc && (sel == 2'd1);
    assign wb1.stb = stb && (sel == 2'd1);
    assign wb1.we = we;
    assign wb1.adr = adr;
    assign wb1.dat_i = dat;
    assign wb2.cyc = cyc && (sel == 2'd2);
    assign wb2.stb = stb && (sel == 2'd2);
    assign wb2.we = we;
    assign wb2.adr = adr;
    assign wb2.dat_i = dat;

    logic [63:0] io_in0, io_out0, io_in1, io_out1;
    logic [23:0] io_in2, io_out2;
    logic        irq0, irq1, irq2;

    wb_io_ports #(.N_CH(4), .DW(16), .WAIT(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .wb(wb0), .io_in_i(io_in0), .io_out_o(io_out0), .irq_o(irq0));
    wb_io_ports #(.N_CH(4), .DW(16), .WAIT(3)) dut1 (
        .clk_i(clk), .rst_i(rst), .wb(wb1), .io_in_i(io_in1), .io_out_o(io_out1), .irq_o(irq1));
    wb_io_ports #(.N_CH(3), .DW(8), .WAIT(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .wb(wb2), .io_in_i(io_in2), .io_out_o(io_out2), .irq_o(irq2));

    logic        ack_m, stall_m;
    logic [15:0] dat_m;
    always_comb begin
        case (sel)
            2'd0:    begin ack_m = wb0.ack; stall_m = wb0.stall; dat_m = wb0.dat_o; end
            2'd1:    begin ack_m = wb1.ack; stall_m = wb1.stall; dat_m = wb1.dat_o; end
            default: begin ack_m = wb2.ack; stall_m = wb2.stall; dat_m = wb2.dat_o; end
        endcase
    end

    logic [15:0] exp_q[$];
    int chk_cnt = 0;
    int pass_cnt = 0;

    // Called at a falling edge: request is accepted on the next rising edge.
    task automatic do_access(input logic w, input logic [1:0] bank, input logic [1:0] ch,
                             input logic [15:0] wdat, input logic [15:0] rexp,
                             output int lat, output int stl);
        logic [15:0] e;
        cyc = 1'b1; stb = 1'b1; we = w; adr = {bank, ch}; dat = wdat;
        if (!w) exp_q.push_back(rexp);
        lat = 0; stl = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            stb = 1'b0;
            if (stall_m) stl++;
            if (ack_m) begin
                lat = k;
                if (!w) begin
                    e = exp_q.pop_front();
                    chk_cnt++;
                    if (dat_m !== e) $display("FAIL rd_data sel=%0d adr=%h got=%h exp=%h", sel, adr, dat_m, e);
                    else pass_cnt++;
                end
            end
        end
        cyc = 1'b0; we = 1'b0;
        if (lat == 0) begin
            chk_cnt++;
            $display("FAIL ack_timeout sel=%0d adr=%h got=no ack exp=ack", sel, adr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = 2'd0;
        io_in0 = '0; io_in1 = '0; io_in2 = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk_cnt++; if (ack_m !== 1'b0) $display("FAIL rst_ack sel=%0d got=%b exp=0", s, ack_m); else pass_cnt++;
            chk_cnt++; if (stall_m !== 1'b0) $display("FAIL rst_stall sel=%0d got=%b exp=0", s, stall_m); else pass_cnt++;
            chk_cnt++; if (dat_m !== 16'h0) $display("FAIL rst_dat sel=%0d got=%h exp=0", s, dat_m); else pass_cnt++;
        end
        chk_cnt++;
        if ({io_out0, io_out1, io_out2} !== '0) $display("FAIL rst_io_out got=%h/%h/%h exp=0", io_out0, io_out1, io_out2);
        else pass_cnt++;
        chk_cnt++;
        if ({irq0, irq1, irq2} !== 3'b000) $display("FAIL rst_irq got=%b exp=000", {irq0, irq1, irq2}); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        sel = 2'd0;
    endtask

    task automatic test_write_read();
        int lat, stl;
        sel = 2'd0;
        do_access(1'b1, 2'b00, 2'd2, 16'hA5A5, 16'h0, lat, stl);
        chk_cnt++; if (lat !== 1) $display("FAIL wr_latency got=%0d exp=1", lat); else pass_cnt++;
        chk_cnt++; if (stl !== 0) $display("FAIL wr_stall got=%0d exp=0", stl); else pass_cnt++;
        chk_cnt++;
        if (io_out0 !== 64'h0000_A5A5_0000_0000) $display("FAIL wr_io_out got=%h exp=0000a5a500000000", io_out0);
        else pass_cnt++;
        do_access(1'b0, 2'b00, 2'd2, 16'h0, 16'hA5A5, lat, stl);
        chk_cnt++; if (lat !== 1) $display("FAIL rd_latency got=%0d exp=1", lat); else pass_cnt++;
        io_in0[63:48] = 16'hBEEF;
        repeat (3) @(negedge clk);
        do_access(1'b0, 2'b01, 2'd3, 16'h0, 16'hBEEF, lat, stl);
        do_access(1'b1, 2'b01, 2'd3, 16'h1357, 16'h0, lat, stl);
        do_access(1'b0, 2'b01, 2'd3, 16'h0, 16'hBEEF, lat, stl);
    endtask

    task automatic test_back_to_back();
        int lat, stl;
        sel = 2'd0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {2'b00, 2'd0}; dat = 16'h1111;
        @(negedge clk);
        chk_cnt++; if (ack_m !== 1'b1) $display("FAIL b2b_ack1 got=%b exp=1", ack_m); else pass_cnt++;
        adr = {2'b00, 2'd1}; dat = 16'h2222;
        @(negedge clk);
        chk_cnt++; if (ack_m !== 1'b1) $display("FAIL b2b_ack2 got=%b exp=1", ack_m); else pass_cnt++;
        stb = 1'b0;
        @(negedge clk);
        chk_cnt++; if (ack_m !== 1'b0) $display("FAIL b2b_ack_end got=%b exp=0", ack_m); else pass_cnt++;
        chk_cnt++;
        if (io_out0[31:0] !== 32'h2222_1111) $display("FAIL b2b_io_out got=%h exp=22221111", io_out0[31:0]);
        else pass_cnt++;
        cyc = 1'b0; we = 1'b0;
        do_access(1'b0, 2'b00, 2'd1, 16'h0, 16'h2222, lat, stl);
    endtask

    task automatic test_wait_states();
        int lat, stl;
        sel = 2'd1;
        io_in1[15:0] = 16'h1234;
        repeat (3) @(negedge clk);
        do_access(1'b0, 2'b01, 2'd0, 16'h0, 16'h1234, lat, stl);
        chk_cnt++; if (lat !== 4) $display("FAIL w3_rd_latency got=%0d exp=4", lat); else pass_cnt++;
        chk_cnt++; if (stl !== 3) $display("FAIL w3_stall_cycles got=%0d exp=3", stl); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (ack_m !== 1'b0) $display("FAIL w3_ack_pulse got=%b exp=0", ack_m); else pass_cnt++;
        do_access(1'b1, 2'b00, 2'd1, 16'h4321, 16'h0, lat, stl);
        chk_cnt++; if (lat !== 4) $display("FAIL w3_wr_latency got=%0d exp=4", lat); else pass_cnt++;
        chk_cnt++;
        if (io_out1[31:16] !== 16'h4321) $display("FAIL w3_io_out got=%h exp=4321", io_out1[31:16]); else pass_cnt++;
        do_access(1'b0, 2'b00, 2'd1, 16'h0, 16'h4321, lat, stl);
    endtask

    task automatic test_abort();
        int lat, stl, acks;
        sel = 2'd2;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {2'b00, 2'd1}; dat = 16'hFF5A;
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack_m) acks++;
        end
        chk_cnt++; if (acks !== 0) $display("FAIL abort_ack got=%0d exp=0", acks); else pass_cnt++;
        chk_cnt++; if (stall_m !== 1'b0) $display("FAIL abort_idle got=%b exp=0", stall_m); else pass_cnt++;
        chk_cnt++; if (io_out2[15:8] !== 8'h5A) $display("FAIL abort_reg got=%h exp=5a", io_out2[15:8]); else pass_cnt++;
        do_access(1'b0, 2'b00, 2'd1, 16'h0, 16'h005A, lat, stl);
        chk_cnt++; if (lat !== 3) $display("FAIL w2_latency got=%0d exp=3", lat); else pass_cnt++;
        chk_cnt++; if (stl !== 2) $display("FAIL w2_stall_cycles got=%0d exp=2", stl); else pass_cnt++;
    endtask

    task automatic test_bad_channel();
        int lat, stl;
        logic [23:0] saved;
        sel = 2'd2;
        saved = io_out2;
        do_access(1'b1, 2'b00, 2'd3, 16'hFFFF, 16'h0, lat, stl);
        chk_cnt++; if (lat !== 3) $display("FAIL badch_wr_ack got=%0d exp=3", lat); else pass_cnt++;
        chk_cnt++; if (io_out2 !== saved) $display("FAIL badch_io_out got=%h exp=%h", io_out2, saved); else pass_cnt++;
        do_access(1'b0, 2'b00, 2'd3, 16'h0, 16'h0000, lat, stl);
        io_in2 = 24'hFFFFFF;
        repeat (3) @(negedge clk);
        do_access(1'b0, 2'b01, 2'd2, 16'h0, 16'h00FF, lat, stl);
        do_access(1'b0, 2'b01, 2'd3, 16'h0, 16'h0000, lat, stl);
    endtask

    task automatic test_irq();
        int lat, stl, first;
        sel = 2'd0;
`ifdef WB_IO_PORTS_IRQ_EN
        do_access(1'b1, 2'b11, 2'd0, 16'h0002, 16'h0, lat, stl);
        do_access(1'b0, 2'b11, 2'd0, 16'h0, 16'h0002, lat, stl);
        io_in0[16] = ~io_in0[16];
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (irq0 && first == 0) first = k;
        end
        chk_cnt++; if (first !== 4) $display("FAIL irq_delay got=%0d exp=4", first); else pass_cnt++;
        do_access(1'b0, 2'b10, 2'd0, 16'h0, 16'h000A, lat, stl);
        do_access(1'b1, 2'b10, 2'd0, 16'h0002, 16'h0, lat, stl);
        @(negedge clk);
        chk_cnt++; if (irq0 !== 1'b0) $display("FAIL irq_w1c got=%b exp=0", irq0); else pass_cnt++;
        do_access(1'b0, 2'b10, 2'd0, 16'h0, 16'h0008, lat, stl);
        io_in0[16] = ~io_in0[16];
        repeat (2) @(negedge clk);
        do_access(1'b1, 2'b10, 2'd0, 16'h0002, 16'h0, lat, stl);
        do_access(1'b0, 2'b10, 2'd0, 16'h0, 16'h000A, lat, stl);
        chk_cnt++; if (irq0 !== 1'b1) $display("FAIL irq_set_wins got=%b exp=1", irq0); else pass_cnt++;
`else
        do_access(1'b1, 2'b11, 2'd0, 16'hFFFF, 16'h0, lat, stl);
        do_access(1'b0, 2'b11, 2'd0, 16'h0, 16'h0000, lat, stl);
        do_access(1'b0, 2'b00, 2'd0, 16'h0, 16'h1111, lat, stl);
        io_in0[16] = ~io_in0[16];
        repeat (6) @(negedge clk);
        do_access(1'b0, 2'b10, 2'd0, 16'h0, 16'h0000, lat, stl);
        chk_cnt++; if (irq0 !== 1'b0) $display("FAIL irq_tied got=%b exp=0", irq0); else pass_cnt++;
`endif
    endtask

    task automatic test_reset_in_wait();
        int lat, stl, acks;
        sel = 2'd2;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {2'b00, 2'd1}; dat = 16'h0;
        @(negedge clk);
        chk_cnt++; if (stall_m !== 1'b1) $display("FAIL rstw_stall got=%b exp=1", stall_m); else pass_cnt++;
        stb = 1'b0; rst = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack_m) acks++;
        end
        chk_cnt++; if (acks !== 0) $display("FAIL rstw_ack got=%0d exp=0", acks); else pass_cnt++;
        chk_cnt++; if (stall_m !== 1'b0) $display("FAIL rstw_stall_clr got=%b exp=0", stall_m); else pass_cnt++;
        chk_cnt++; if (dat_m !== 16'h0) $display("FAIL rstw_dat got=%h exp=0", dat_m); else pass_cnt++;
        chk_cnt++;
        if ({io_out0, io_out1, io_out2} !== '0) $display("FAIL rstw_io_out got=%h/%h/%h exp=0", io_out0, io_out1, io_out2);
        else pass_cnt++;
        chk_cnt++; if ({irq0, irq1, irq2} !== 3'b000) $display("FAIL rstw_irq got=%b exp=000", {irq0, irq1, irq2}); else pass_cnt++;
        rst = 1'b0; cyc = 1'b0;
        do_access(1'b1, 2'b00, 2'd2, 16'h0077, 16'h0, lat, stl);
        chk_cnt++; if (lat !== 3) $display("FAIL post_rst_latency got=%0d exp=3", lat); else pass_cnt++;
        chk_cnt++; if (io_out2[23:16] !== 8'h77) $display("FAIL post_rst_io_out got=%h exp=77", io_out2[23:16]); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_wait_states();
        test_abort();
        test_bad_channel();
        test_irq();
        test_reset_in_wait();
        chk_cnt++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
